// File: rtl/nibble_serial_addsub_pkg.sv
// Shared constants for the nibble-serial adder/subtractor: FSM encoding, op codes, size helpers.
package nibble_serial_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

  function automatic int cnt_width(input int width);
    return (width / 4 > 1) ? $clog2(width / 4) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_addsub_nibble.sv
// Combinational 4-bit carry-lookahead add slice with optional b inversion.
// c3 is the carry into bit 3, exposed so the top nibble can derive signed overflow.
module addsub_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  input  logic       inv_b,
  output logic [3:0] s,
  output logic       c4,
  output logic       c3
);

  logic [3:0] bb;
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign bb = b ^ {4{inv_b}};
  assign g  = a & bb;
  assign p  = a ^ bb;

  // Every carry is a flat sum of products of g/p/c0: no ripple through the slice.
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);

  assign s = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/nibble_serial_addsub.sv
// Sequential WIDTH-bit add/sub, one nibble per clock: result valid N=WIDTH/4 cycles after accept.
// Operands taken only in IDLE; DONE holds result and flags until out_ready.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = nib_count(WIDTH);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [3:0] nib_s;
  logic       nib_c4;
  logic       nib_c3;

  // Operands shift right each RUN edge so the slice always sees bits [3:0].
  addsub_nibble u_slice (
    .a     (a_q[3:0]),
    .b     (b_q[3:0]),
    .c0    (carry_q),
    .inv_b (op_q),
    .s     (nib_s),
    .c4    (nib_c4),
    .c3    (nib_c3)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          // Subtract computes a + ~b + ~cin, i.e. a - b - cin.
          carry_d = (op == OP_SUB) ? ~cin : cin;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d = a_q >> 4;
        b_d = b_q >> 4;
        result_d[{count_q, 2'b00} +: 4] = nib_s;
        carry_d = nib_c4;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          cout_d  = (op_q == OP_SUB) ? ~nib_c4 : nib_c4;
          ovf_d   = nib_c3 ^ nib_c4;
          zero_d  = (result_d == '0);
          count_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      carry_q  <= 1'b0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub (WIDTH=32): directed vector table, corner sequences, random ops vs arithmetic model.
module tb_nibble_serial_addsub;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] r;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Exact integer arithmetic: carry/borrow from the unsigned value, overflow from the signed value.
  function automatic void model(input logic mop, input logic [31:0] ma, input logic [31:0] mb,
                                input logic mcin, output logic [31:0] r, output logic co,
                                output logic ov, output logic z);
    longint ua, ub, sa, sb, us, ss, c;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    c  = longint'(mcin);
    if (mop) begin
      us = ua - ub - c;
      ss = sa - sb - c;
      co = (us < 0);
    end else begin
      us = ua + ub + c;
      ss = sa + sb + c;
      co = (us > 64'sh0_FFFF_FFFF);
    end
    r  = us[31:0];
    ov = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    z  = (r == 32'h0);
  endfunction

  task automatic start_op(input logic sop, input logic [31:0] sa, input logic [31:0] sb, input logic scin);
    op       = sop;
    a        = sa;
    b        = sb;
    cin      = scin;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called 1 time unit after the accept edge; out_valid must rise after exactly 8 more edges.
  task automatic wait_done(input string tag, input logic [31:0] er, input logic eco, input logic eov, input logic ez);
    int cycles = 0;
    while (out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk({tag, "_latency"}, cycles, 8);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, cout, eco);
    chk({tag, "_ovf"}, ovf, eov);
    chk({tag, "_zero"}, zero, ez);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("back_to_idle", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] mr;
    logic        mco, mov, mz;
    logic        rop, rcin;
    logic [31:0] ra, rb;

    vecs[0] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0010, 32'h0000_000F, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {cout, ovf, zero}, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done($sformatf("vec%0d", i), vecs[i].r, vecs[i].co, vecs[i].ov, vecs[i].z);
      release_out();
    end

    // Backpressure: DONE held 5 cycles while new operands are offered.
    model(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, mr, mco, mov, mz);
    start_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done("bp_first", mr, mco, mov, mz);
    op       = 1'b1;
    a        = 32'd100;
    b        = 32'd7;
    cin      = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_result", result, 32'h2345_6789);
      chk("bp_hold_flags", {out_valid, in_ready, cout, ovf, zero}, 5'b10000);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept_next", in_ready, 1'b0);
    wait_done("bp_second", 32'd93, 1'b0, 1'b0, 1'b0);
    release_out();

    // Asynchronous reset after the 3rd RUN edge.
    start_op(1'b0, 32'hDEAD_BEEF, 32'h0101_0101, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_in_ready", in_ready, 1'b1);
    chk("rst_mid_result", result, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_no_valid", out_valid, 1'b0);
    model(1'b1, 32'hCAFE_0000, 32'h0000_1234, 1'b0, mr, mco, mov, mz);
    start_op(1'b1, 32'hCAFE_0000, 32'h0000_1234, 1'b0);
    wait_done("after_rst", mr, mco, mov, mz);
    release_out();

    for (int i = 0; i < 24; i++) begin
      rop  = 1'($urandom_range(0, 1));
      rcin = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      if (i % 6 == 1) ra = 32'h8000_0000;
      if (i % 6 == 3) rb = 32'h7FFF_FFFF;
      if (i % 6 == 5) rb = ra;
      model(rop, ra, rb, rcin, mr, mco, mov, mz);
      start_op(rop, ra, rb, rcin);
      wait_done($sformatf("rand%0d", i), mr, mco, mov, mz);
      release_out();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
